// File: rtl/huffman_pkg.sv
// Shared types and helpers for the multi-table Huffman tree-walk decoder.
// Contents: decoder state enum, error code constants, a ceil-log2 helper
// for parameter sizing, and node-word decode helpers (leaf test, child index).
package huffman_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWalk,
        StOut,
        StErr
    } state_e;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrOverlen = 2'd1;
    localparam logic [1:0] ErrBadPtr  = 2'd2;

    // Smallest r with 2**r >= v (0 for v <= 1).
    function automatic int unsigned clogb2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Tree words below numcodes are leaf symbols; the rest encode a child node.
    function automatic logic node_is_leaf(input int unsigned word, input int unsigned numcodes);
        return word < numcodes;
    endfunction

    function automatic int unsigned node_child(input int unsigned word,
                                               input int unsigned numcodes);
        return word - numcodes;
    endfunction

endpackage

// File: rtl/huffman_tree_ram.sv
// Banked tree memory: NTABLES banks of 2*NUMCODES words, one write port and
// one synchronous read port. Read-before-write: a read and a write to the
// same word in one cycle return the old contents.
// Ports:
//   clk_i                               clock
//   wr_en_i, wr_tbl_i, wr_addr_i, wr_data_i   write port (bank, word address, data)
//   rd_en_i, rd_tbl_i, rd_addr_i        read request (bank, word address)
//   rd_data_o                           read data, valid the cycle after rd_en_i
module huffman_tree_ram
    import huffman_pkg::*;
#(
    parameter int unsigned NUMCODES = 288,
    parameter int unsigned OUTWIDTH = 10,
    parameter int unsigned NTABLES  = 2,
    parameter int unsigned TW       = 1,
    parameter int unsigned AW       = 10
) (
    input  logic                clk_i,
    input  logic                wr_en_i,
    input  logic [TW-1:0]       wr_tbl_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [OUTWIDTH-1:0] wr_data_i,
    input  logic                rd_en_i,
    input  logic [TW-1:0]       rd_tbl_i,
    input  logic [AW-1:0]       rd_addr_i,
    output logic [OUTWIDTH-1:0] rd_data_o
);

    localparam int unsigned Words = 2 * NUMCODES;
    localparam int unsigned Depth = NTABLES * Words;
    localparam int unsigned IW    = clogb2(Depth);

    logic [OUTWIDTH-1:0] mem [Depth];
    logic [OUTWIDTH-1:0] rd_data_q;

    function automatic logic [IW-1:0] flat_idx(input logic [TW-1:0] t, input logic [AW-1:0] a);
        return IW'(t) * IW'(Words) + IW'(a);
    endfunction

    always_ff @(posedge clk_i) begin
        if (wr_en_i && (32'(wr_addr_i) < Words) && (32'(wr_tbl_i) < NTABLES)) begin
            mem[flat_idx(wr_tbl_i, wr_addr_i)] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem[flat_idx(rd_tbl_i, rd_addr_i)];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/huffman_decoder_mt.sv
// Bit-serial Huffman tree-walk decoder with NTABLES independently loaded trees.
// Each accepted bit looks up {node,bit} in the selected tree; a leaf word ends
// the symbol, an internal word moves the walk to its child node.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_start, i_clear          (re)start decoding / return to idle
//   i_tsel                    tree used for the next symbol (sampled at its first bit)
//   i_valid, i_bit, i_ready   bitstream handshake, one bit per transfer
//   wr_en/wr_tbl/wr_addr/wr_data   tree load port, honoured only while idle
//   o_valid, o_ready          symbol handshake
//   o_sym, o_len, o_tbl       decoded symbol, code length, producing tree
//   o_err, o_errcode          sticky error flag and cause (1 overlength, 2 bad pointer)
module huffman_decoder_mt
    import huffman_pkg::*;
#(
    parameter int unsigned NUMCODES = 288,
    parameter int unsigned OUTWIDTH = 10,
    parameter int unsigned NTABLES  = 2,
    parameter int unsigned MAXBITS  = 15,
    localparam int unsigned TW = (clogb2(NTABLES) > 1) ? clogb2(NTABLES) : 1,
    localparam int unsigned AW = clogb2(2 * NUMCODES - 1),
    localparam int unsigned LW = clogb2(MAXBITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_clear,
    input  logic [TW-1:0]       i_tsel,
    input  logic                i_valid,
    input  logic                i_bit,
    output logic                i_ready,
    input  logic                wr_en,
    input  logic [TW-1:0]       wr_tbl,
    input  logic [AW-1:0]       wr_addr,
    input  logic [OUTWIDTH-1:0] wr_data,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [OUTWIDTH-1:0] o_sym,
    output logic [LW-1:0]       o_len,
    output logic [TW-1:0]       o_tbl,
    output logic                o_err,
    output logic [1:0]          o_errcode
);

    localparam int unsigned PW = AW - 1;

    state_e              state_q, state_d;
    logic [PW-1:0]       tpos_q, tpos_d;
    logic [LW-1:0]       depth_q, depth_d;
    logic                pend_q, pend_d;
    logic [TW-1:0]       tbl_q, tbl_d;
    logic [OUTWIDTH-1:0] sym_q, sym_d;
    logic [LW-1:0]       len_q, len_d;
    logic [TW-1:0]       otbl_q, otbl_d;
    logic                err_q, err_d;
    logic [1:0]          errcode_q, errcode_d;

    logic [OUTWIDTH-1:0] rd_data;
    logic [OUTWIDTH-1:0] child_w;
    logic                word_leaf, bad_ptr, overlen, hit_leaf, hit_err, accept;
    logic [PW-1:0]       cur_tpos;
    logic [TW-1:0]       cur_tbl;

    huffman_tree_ram #(
        .NUMCODES(NUMCODES),
        .OUTWIDTH(OUTWIDTH),
        .NTABLES (NTABLES),
        .TW      (TW),
        .AW      (AW)
    ) u_ram (
        .clk_i    (clk),
        .wr_en_i  (wr_en && (state_q == StIdle)),
        .wr_tbl_i (wr_tbl),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .rd_en_i  (accept),
        .rd_tbl_i (cur_tbl),
        .rd_addr_i({cur_tpos, i_bit}),
        .rd_data_o(rd_data)
    );

    // Decode of the word returned for the previous bit (meaningful only when pend_q).
    always_comb begin
        word_leaf = node_is_leaf(32'(rd_data), NUMCODES);
        child_w   = OUTWIDTH'(node_child(32'(rd_data), NUMCODES));
        bad_ptr   = !word_leaf && (child_w >= OUTWIDTH'(NUMCODES - 1));
        overlen   = !word_leaf && (depth_q == LW'(MAXBITS));
        hit_leaf  = pend_q && word_leaf;
        hit_err   = pend_q && (overlen || bad_ptr);
        i_ready   = (state_q == StWalk) && !(hit_leaf || hit_err);
        accept    = i_valid && i_ready;
        // Forward the child node straight into the next lookup so an internal
        // node does not cost a bubble.
        cur_tpos  = (pend_q && !word_leaf) ? PW'(child_w) : tpos_q;
        cur_tbl   = (depth_q == '0) ? i_tsel : tbl_q;
    end

    always_comb begin
        state_d   = state_q;
        tpos_d    = tpos_q;
        depth_d   = depth_q;
        pend_d    = pend_q;
        tbl_d     = tbl_q;
        sym_d     = sym_q;
        len_d     = len_q;
        otbl_d    = otbl_q;
        err_d     = err_q;
        errcode_d = errcode_q;

        if (i_clear) begin
            state_d = StIdle;
            pend_d  = 1'b0;
        end else if (i_start) begin
            state_d   = StWalk;
            tpos_d    = '0;
            depth_d   = '0;
            pend_d    = 1'b0;
            err_d     = 1'b0;
            errcode_d = ErrNone;
        end else begin
            unique case (state_q)
                StWalk: begin
                    if (pend_q) begin
                        pend_d = 1'b0;
                        if (word_leaf) begin
                            state_d = StOut;
                            sym_d   = rd_data;
                            len_d   = depth_q;
                            otbl_d  = tbl_q;
                        end else if (overlen) begin
                            state_d   = StErr;
                            err_d     = 1'b1;
                            errcode_d = ErrOverlen;
                        end else if (bad_ptr) begin
                            state_d   = StErr;
                            err_d     = 1'b1;
                            errcode_d = ErrBadPtr;
                        end else begin
                            tpos_d = PW'(child_w);
                        end
                    end
                    if (accept) begin
                        pend_d  = 1'b1;
                        tpos_d  = cur_tpos;
                        depth_d = (depth_q == '1) ? depth_q : depth_q + 1'b1;
                        if (depth_q == '0) begin
                            tbl_d = i_tsel;
                        end
                    end
                end
                StOut: begin
                    if (o_ready) begin
                        state_d = StWalk;
                        tpos_d  = '0;
                        depth_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tpos_q    <= '0;
            depth_q   <= '0;
            pend_q    <= 1'b0;
            tbl_q     <= '0;
            sym_q     <= '0;
            len_q     <= '0;
            otbl_q    <= '0;
            err_q     <= 1'b0;
            errcode_q <= ErrNone;
        end else begin
            state_q   <= state_d;
            tpos_q    <= tpos_d;
            depth_q   <= depth_d;
            pend_q    <= pend_d;
            tbl_q     <= tbl_d;
            sym_q     <= sym_d;
            len_q     <= len_d;
            otbl_q    <= otbl_d;
            err_q     <= err_d;
            errcode_q <= errcode_d;
        end
    end

    assign o_valid   = (state_q == StOut);
    assign o_sym     = sym_q;
    assign o_len     = len_q;
    assign o_tbl     = otbl_q;
    assign o_err     = err_q;
    assign o_errcode = errcode_q;

endmodule

// File: tb/tb_huffman_decoder_mt.sv
// Directed bench for huffman_decoder_mt. Table 0 holds codes 0->"0", 1->"10",
// 2->"11"; table 1 is the mirror (0->"1"). Inputs change on the falling edge
// and outputs are sampled there too.
module tb_huffman_decoder_mt;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start, i_clear, i_valid, i_bit, i_ready;
    logic [0:0] i_tsel;
    logic       wr_en;
    logic [0:0] wr_tbl;
    logic [9:0] wr_addr, wr_data;
    logic       o_valid, o_ready, o_err;
    logic [9:0] o_sym;
    logic [3:0] o_len;
    logic [0:0] o_tbl;
    logic [1:0] o_errcode;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    huffman_decoder_mt dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_clear  (i_clear),
        .i_tsel   (i_tsel),
        .i_valid  (i_valid),
        .i_bit    (i_bit),
        .i_ready  (i_ready),
        .wr_en    (wr_en),
        .wr_tbl   (wr_tbl),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_sym    (o_sym),
        .o_len    (o_len),
        .o_tbl    (o_tbl),
        .o_err    (o_err),
        .o_errcode(o_errcode)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int t, input int a, input int d);
        wr_en   = 1'b1;
        wr_tbl  = 1'(t);
        wr_addr = 10'(a);
        wr_data = 10'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
    endtask

    // Offer one bit; returns on the falling edge right after it was taken.
    task automatic send_bit(input logic b);
        int n = 0;
        i_valid = 1'b1;
        i_bit   = b;
        #1;
        while (!i_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!i_ready) check_eq("bit_accept_timeout", 0, 1);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Called right after send_bit of the final code bit.
    task automatic expect_sym(input string tag, input int sym, input int len, input int tbl);
        int n = 0;
        while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_lat"}, n, 1);
        check_eq({tag, "_sym"}, int'(o_sym), sym);
        check_eq({tag, "_len"}, int'(o_len), len);
        check_eq({tag, "_tbl"}, int'(o_tbl), tbl);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, int'(o_valid), 0);
        check_eq({tag, "_err"}, int'(o_err), 0);
        check_eq({tag, "_errcode"}, int'(o_errcode), 0);
        check_eq({tag, "_sym"}, int'(o_sym), 0);
        check_eq({tag, "_len"}, int'(o_len), 0);
        check_eq({tag, "_tbl"}, int'(o_tbl), 0);
        check_eq({tag, "_ready"}, int'(i_ready), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_start = 1'b0; i_clear = 1'b0; i_tsel = 1'b0;
        i_valid = 1'b0; i_bit = 1'b0; wr_en = 1'b0; wr_tbl = 1'b0;
        wr_addr = '0; wr_data = '0; o_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        wr(0, 0, 0); wr(0, 1, 289); wr(0, 2, 1); wr(0, 3, 2);
        wr(1, 0, 289); wr(1, 1, 0);

        // 1: stream 0,1,0,1,1 with the consumer always ready
        o_ready = 1'b1;
        pulse_start();
        send_bit(1'b0);
        expect_sym("t1_a", 0, 1, 0);
        @(negedge clk);
        check_eq("t1_once", int'(o_valid), 0);
        send_bit(1'b1); send_bit(1'b0);
        expect_sym("t1_b", 1, 2, 0);
        send_bit(1'b1); send_bit(1'b1);
        expect_sym("t1_c", 2, 2, 0);
        @(negedge clk);

        // 2: backpressure holds the symbol and stalls the bitstream
        o_ready = 1'b0;
        send_bit(1'b0);
        expect_sym("t2_a", 0, 1, 0);
        i_valid = 1'b1;
        i_bit   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t2_hold_valid", int'(o_valid), 1);
            check_eq("t2_hold_sym", int'(o_sym), 0);
            check_eq("t2_hold_ready", int'(i_ready), 0);
        end
        o_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b0);
        expect_sym("t2_b", 1, 2, 0);
        @(negedge clk);

        // 3: per-symbol table select, latched only at the first bit
        i_tsel = 1'b0;
        send_bit(1'b0);
        expect_sym("t3_a", 0, 1, 0);
        @(negedge clk);
        i_tsel = 1'b1;
        send_bit(1'b1);
        expect_sym("t3_b", 0, 1, 1);
        @(negedge clk);
        i_tsel = 1'b0;
        send_bit(1'b1);
        i_tsel = 1'b1;
        send_bit(1'b1);
        expect_sym("t3_c", 2, 2, 0);
        @(negedge clk);
        i_tsel = 1'b0;

        // 4: bad node pointer, then recovery through i_start
        pulse_clear();
        wr(0, 1, 288 + 400);
        pulse_start();
        send_bit(1'b1);
        check_eq("t4_ready_pend", int'(i_ready), 0);
        @(negedge clk);
        check_eq("t4_err", int'(o_err), 1);
        check_eq("t4_code", int'(o_errcode), 2);
        check_eq("t4_ready", int'(i_ready), 0);
        check_eq("t4_valid", int'(o_valid), 0);
        @(negedge clk);
        check_eq("t4_sticky", int'(o_err), 1);
        pulse_start();
        check_eq("t4_clr_err", int'(o_err), 0);
        check_eq("t4_clr_code", int'(o_errcode), 0);
        send_bit(1'b0);
        expect_sym("t4_s", 0, 1, 0);
        @(negedge clk);

        // 5: 15-deep chain of internal nodes -> overlength on the 15th lookup
        pulse_clear();
        for (int k = 0; k < 15; k++) wr(0, 2 * k, 289 + k);
        pulse_start();
        for (int k = 1; k <= 15; k++) begin
            send_bit(1'b0);
            check_eq("t5_no_err", int'(o_err), 0);
        end
        @(negedge clk);
        check_eq("t5_err", int'(o_err), 1);
        check_eq("t5_code", int'(o_errcode), 1);
        check_eq("t5_valid", int'(o_valid), 0);

        // 6: reset in OUT and mid-walk; memory kept; writes outside IDLE ignored
        pulse_clear();
        wr(0, 0, 0); wr(0, 1, 289); wr(0, 2, 1);
        pulse_start();
        o_ready = 1'b0;
        send_bit(1'b0);
        @(negedge clk);
        check_eq("t6_in_out", int'(o_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("t6_rst_out");
        pulse_start();
        send_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_rst_walk_valid", int'(o_valid), 0);
        check_eq("t6_rst_walk_ready", int'(i_ready), 0);
        o_ready = 1'b1;
        pulse_start();
        wr(0, 0, 5);
        wr(0, 3, 7);
        send_bit(1'b0);
        expect_sym("t6_a", 0, 1, 0);
        @(negedge clk);
        send_bit(1'b1); send_bit(1'b1);
        expect_sym("t6_b", 2, 2, 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
